wb_find_reader: RTL
===================

// Module: wb_find_reader
// PURPOSE
// - Wishbone classic-cycle master; the initiator side of the search-unit result slave.
// - On i_start it soft-resets the search units, then polls their done bits.
// - It reads the SEQ and E words of each finished unit exactly once.
// - Each result is emitted on a valid/ready stream; a one-cycle o_done pulse follows the last one.
// - Slave map (byte offsets from BASE_ADR):
//   - 0x00 CTRL (W, bit0 = soft reset)
//   - 0x04 STATUS (R, done[PARALLEL_UNITS-1:0])
//   - 0x08+8*i SEQ_i (R)
//   - 0x0C+8*i E_i (R)
// PARAMETERS
// BASE_ADR        32'h3000_0000  slave base address
// SEQ_WIDTH       8              valid low bits of SEQ word
// E_WIDTH         16             valid low bits of E word
// PARALLEL_UNITS  2              number of units polled (1..16)
// POLL_GAP        16             idle cycles between STATUS reads (>=1)
// TIMEOUT_CYCLES  1024           ack watchdog limit (only with macro)
// PORTS
// wb_clk_i    in   1   clock
// wb_rst_ni   in   1   reset, asynchronous, active-low
// i_start     in   1   start run; sampled in IDLE only
// o_busy      out  1   high from accepted start until o_done/o_timeout
// o_done      out  1   1-cycle pulse, all units collected
// o_timeout   out  1   1-cycle pulse, ack watchdog fired (macro only, else 0)
// wbm_cyc_o   out  1   bus cycle
// wbm_stb_o   out  1   strobe
// wbm_we_o    out  1   write enable
// wbm_sel_o   out  4   byte select, always 4'hF
// wbm_adr_o   out  32  address
// wbm_dat_o   out  32  write data
// wbm_dat_i   in   32  read data
// wbm_ack_i   in   1   acknowledge
// o_valid     out  1   result valid
// i_ready     in   1   result accepted
// o_unit      out  $clog2(PARALLEL_UNITS) (min 1)  unit index
// o_seq       out  SEQ_WIDTH  wbm_dat_i[SEQ_WIDTH-1:0] of SEQ read
// o_e         out  E_WIDTH    wbm_dat_i[E_WIDTH-1:0] of E read
// BEHAVIOUR
// - Reset: all outputs 0; FSM = IDLE; collected mask = 0; gap counter = 0.
// - Bus cycle: cyc/stb/we/adr/dat registered.
//   - Held stable until the cycle wbm_ack_i=1; read data is captured in that cycle.
//   - cyc/stb drop on the next edge; at least one idle cycle between cycles.
//   - ack seen while cyc=0 is ignored.
// - FSM:
//   - IDLE -i_start-> WR_RST1: write 1 to CTRL.
//   - WR_RST1 -ack-> WR_RST0: write 0 to CTRL.
//   - WR_RST0 -ack-> GAP.
//   - GAP: count POLL_GAP cycles, then -> POLL.
//   - POLL: read STATUS; on ack, pending = done & ~collected; pending==0 -> GAP, else -> RD_SEQ.
//   - RD_SEQ: read SEQ of the lowest set pending bit i; ack -> RD_E.
//   - RD_E: read E of unit i; ack -> OUT.
//   - OUT: o_valid=1, o_unit=i; stay until i_ready; then set collected[i].
//     - collected all-ones -> FIN; next pending bit -> RD_SEQ; else -> GAP.
//   - FIN: o_done=1 for one cycle, o_busy=0 -> IDLE.
// - o_valid/o_unit/o_seq/o_e hold stable while o_valid && !i_ready; no bus activity during OUT.
// - STATUS bits >= PARALLEL_UNITS are ignored; a done bit for an already-collected unit is ignored.
// - i_start while o_busy is ignored; i_start and o_done in the same cycle: start is not accepted.
// - Async reset mid-transaction: cyc/stb drop immediately; no result emitted.
// CONFIGURATION
// - WB_FIND_READER_TIMEOUT_EN defined: per-transaction counter resets at cyc rise.
//   - If the count reaches TIMEOUT_CYCLES without ack: drop cyc/stb, pulse o_timeout, clear o_busy, -> IDLE.
//   - Collected mask is cleared on the next start.
// - Not defined: no counter; the master waits for ack indefinitely; o_timeout tied 0.
// TESTING
// - Start, slave acks in 1 cycle, STATUS=0x3 on first poll:
//   - bus writes CTRL=1 then CTRL=0, reads 0x04, 0x08, 0x0C, 0x10, 0x14;
//   - two results unit0 then unit1; o_done once.
// - STATUS=0x0 for 3 polls, then 0x2, then 0x3:
//   - polls spaced POLL_GAP+ack cycles; unit1 emitted before unit0; each emitted once.
// - SEQ word 0xDEADBEA5, E word 0x1234ABCD -> o_seq=8'hA5, o_e=16'hABCD.
// - i_ready low 10 cycles in OUT -> outputs stable, cyc=0 throughout; i_start pulses ignored.
// - wb_rst_ni low while stb is waiting for ack -> cyc/stb=0 the same cycle; all outputs 0.
// - Macro defined, slave never acks the STATUS read -> o_timeout pulse after TIMEOUT_CYCLES, o_busy=0, FSM in IDLE.

Source files
------------

// File: rtl/wb_find_reader.sv
// wb_find_reader: Wishbone classic-cycle master for the search-unit result slave.
// Soft-resets the units, polls STATUS every POLL_GAP idle cycles, reads SEQ/E of
// each newly finished unit once and streams the results out on a valid/ready port.
// Optional ack watchdog: define WB_FIND_READER_TIMEOUT_EN.
module wb_find_reader #(
  parameter logic [31:0] BASE_ADR       = 32'h3000_0000,
  parameter int unsigned SEQ_WIDTH      = 8,
  parameter int unsigned E_WIDTH        = 16,
  parameter int unsigned PARALLEL_UNITS = 2,
  parameter int unsigned POLL_GAP       = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  localparam int unsigned UW = (PARALLEL_UNITS > 1) ? $clog2(PARALLEL_UNITS) : 1
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_ni,
  input  logic                 i_start,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_timeout,
  output logic                 wbm_cyc_o,
  output logic                 wbm_stb_o,
  output logic                 wbm_we_o,
  output logic [3:0]           wbm_sel_o,
  output logic [31:0]          wbm_adr_o,
  output logic [31:0]          wbm_dat_o,
  input  logic [31:0]          wbm_dat_i,
  input  logic                 wbm_ack_i,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [UW-1:0]        o_unit,
  output logic [SEQ_WIDTH-1:0] o_seq,
  output logic [E_WIDTH-1:0]   o_e
);

  localparam int unsigned GW = (POLL_GAP > 1) ? $clog2(POLL_GAP + 1) : 1;

  typedef enum logic [3:0] {
    StIdle, StWrRst1, StWrRst0, StGap, StPoll, StRdSeq, StRdE, StOut, StFin
  } state_e;

  state_e                    state_q;
  logic [PARALLEL_UNITS-1:0] collected_q;
  logic [PARALLEL_UNITS-1:0] pending_q;
  logic [UW-1:0]             unit_q;
  logic [GW-1:0]             gap_q;

  logic                      bus_we;
  logic [31:0]               bus_adr;
  logic [31:0]               bus_dat;
  logic [PARALLEL_UNITS-1:0] status_pend;
  logic [PARALLEL_UNITS-1:0] unit_onehot;
  logic [PARALLEL_UNITS-1:0] coll_next;
  logic [PARALLEL_UNITS-1:0] pend_next;

  // Upper read-data bits are legitimately unused for narrow result fields.
  logic unused_dat;
  assign unused_dat = ^wbm_dat_i;

  assign wbm_sel_o = 4'hF;

  // Index of the lowest set bit; callers guarantee the mask is non-zero.
  function automatic logic [UW-1:0] lowest(input logic [PARALLEL_UNITS-1:0] m);
    logic [UW-1:0] r;
    r = '0;
    for (int i = PARALLEL_UNITS - 1; i >= 0; i--) begin
      if (m[i]) r = UW'(i);
    end
    return r;
  endfunction

  // Address/data of the bus cycle belonging to the current state, plus pending-mask bookkeeping.
  always_comb begin
    bus_we  = 1'b0;
    bus_dat = '0;
    bus_adr = BASE_ADR;
    case (state_q)
      StWrRst1: begin
        bus_we  = 1'b1;
        bus_dat = 32'd1;
      end
      StWrRst0: bus_we = 1'b1;
      StPoll:   bus_adr = BASE_ADR + 32'h4;
      StRdSeq:  bus_adr = BASE_ADR + 32'h8 + (32'(unit_q) << 3);
      StRdE:    bus_adr = BASE_ADR + 32'hC + (32'(unit_q) << 3);
      default:  ;
    endcase

    for (int i = 0; i < PARALLEL_UNITS; i++) begin
      unit_onehot[i] = (unit_q == UW'(i));
    end
    status_pend = wbm_dat_i[PARALLEL_UNITS-1:0] & ~collected_q;
    coll_next   = collected_q | unit_onehot;
    pend_next   = pending_q & ~coll_next;
  end

`ifdef WB_FIND_READER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q;
`else
  assign o_timeout = 1'b0;
`endif

  // Control FSM with registered bus and stream outputs.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q     <= StIdle;
      collected_q <= '0;
      pending_q   <= '0;
      unit_q      <= '0;
      gap_q       <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      wbm_cyc_o   <= 1'b0;
      wbm_stb_o   <= 1'b0;
      wbm_we_o    <= 1'b0;
      wbm_adr_o   <= '0;
      wbm_dat_o   <= '0;
      o_valid     <= 1'b0;
      o_unit      <= '0;
      o_seq       <= '0;
      o_e         <= '0;
`ifdef WB_FIND_READER_TIMEOUT_EN
      o_timeout   <= 1'b0;
      tmo_q       <= '0;
`endif
    end else begin
      o_done <= 1'b0;
`ifdef WB_FIND_READER_TIMEOUT_EN
      o_timeout <= 1'b0;
`endif
      case (state_q)
        StIdle: begin
          if (i_start) begin
            o_busy      <= 1'b1;
            collected_q <= '0;
            state_q     <= StWrRst1;
          end
        end

        StWrRst1, StWrRst0, StPoll, StRdSeq, StRdE: begin
          if (!wbm_cyc_o) begin
            // Entering a bus state always starts with cyc low, giving the idle cycle.
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_we_o  <= bus_we;
            wbm_adr_o <= bus_adr;
            wbm_dat_o <= bus_dat;
`ifdef WB_FIND_READER_TIMEOUT_EN
            tmo_q     <= '0;
`endif
          end else if (wbm_ack_i) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            case (state_q)
              StWrRst1: state_q <= StWrRst0;
              StWrRst0: begin
                gap_q   <= '0;
                state_q <= StGap;
              end
              StPoll: begin
                if (status_pend == '0) begin
                  gap_q   <= '0;
                  state_q <= StGap;
                end else begin
                  pending_q <= status_pend;
                  unit_q    <= lowest(status_pend);
                  state_q   <= StRdSeq;
                end
              end
              StRdSeq: begin
                o_seq   <= wbm_dat_i[SEQ_WIDTH-1:0];
                state_q <= StRdE;
              end
              StRdE: begin
                o_e     <= wbm_dat_i[E_WIDTH-1:0];
                o_unit  <= unit_q;
                o_valid <= 1'b1;
                state_q <= StOut;
              end
              default: ;
            endcase
          end
`ifdef WB_FIND_READER_TIMEOUT_EN
          else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            o_timeout <= 1'b1;
            o_busy    <= 1'b0;
            state_q   <= StIdle;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
`endif
        end

        StGap: begin
          if (gap_q == GW'(POLL_GAP - 1)) begin
            gap_q   <= '0;
            state_q <= StPoll;
          end else begin
            gap_q <= gap_q + GW'(1);
          end
        end

        StOut: begin
          if (i_ready) begin
            o_valid     <= 1'b0;
            collected_q <= coll_next;
            if (coll_next == {PARALLEL_UNITS{1'b1}}) begin
              o_done  <= 1'b1;
              o_busy  <= 1'b0;
              state_q <= StFin;
            end else if (pend_next != '0) begin
              pending_q <= pend_next;
              unit_q    <= lowest(pend_next);
              state_q   <= StRdSeq;
            end else begin
              gap_q   <= '0;
              state_q <= StGap;
            end
          end
        end

        // o_done is high during this cycle, so a start here is not seen in StIdle.
        StFin: state_q <= StIdle;

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
